// File: rtl/tpic_pkg.sv
// Shared types and constants for the multi-chain TPIC serial driver.
// Holds the controller state encoding, default geometry and a constant clog2 helper.
package tpic_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_CHAINS = 4;
  localparam int DEFAULT_DIV    = 4;

  typedef enum logic [1:0] {
    CLR   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Number of bits needed to hold values 0 .. value-1 (callers pass N+1 to hold N).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/tpic_chain_ctrl_if.sv
// Request/status and TPIC board-side signal bundle for tpic_chain_ctrl.
// master = relay-image side issuing frames, slave = the chain controller.
interface tpic_chain_ctrl_if
  import tpic_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CHAINS = DEFAULT_CHAINS
) ();

  logic [CHAINS*WIDTH-1:0] data;
  logic                    start;
  logic                    auto;
  logic                    oe;
  logic                    busy;
  logic                    done;
  logic                    sclk;
  logic [CHAINS-1:0]       sout;
  logic                    rck;
  logic                    en_n;
  logic                    clr_n;

  modport master (
    output data, start, auto, oe,
    input  busy, done, sclk, sout, rck, en_n, clr_n
  );

  modport slave (
    input  data, start, auto, oe,
    output busy, done, sclk, sout, rck, en_n, clr_n
  );

endinterface

// File: rtl/tpic_clk_div.sv
// Phase timer for the chain controller: counts DIV enabled cycles and strobes tick
// on the last one; clear holds it at the start of a phase.
module tpic_clk_div
  import tpic_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = clog2(DIV + 1);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/tpic_chain_ctrl.sv
// Shifts CHAINS parallel words into daisy-chained TPIC registers on a shared sclk/rck,
// with a one-deep pending request, auto-refresh and glitch-free output enable control.
module tpic_chain_ctrl
  import tpic_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CHAINS    = DEFAULT_CHAINS,
  parameter int DIV       = DEFAULT_DIV,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic         clk,
  input logic         reset,
  tpic_chain_ctrl_if.slave bus
);

  localparam int            BW      = clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_END = BW'(WIDTH);

  typedef logic [WIDTH-1:0] word_t;
  typedef word_t [CHAINS-1:0] image_t;

  state_t            state, state_d;
  image_t            shadow, shadow_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic [CHAINS-1:0] sout_q, sout_d;
  logic              sclk_q, sclk_d;
  logic              rck_q, rck_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clr_n_q, clr_n_d;
  logic              en_n_q, en_n_d;
  logic              pending, pending_d;
  logic              armed, armed_d;
  logic              tick;

  function automatic logic [CHAINS-1:0] lead_bits(input image_t img);
    logic [CHAINS-1:0] b;
    for (int c = 0; c < CHAINS; c++) b[c] = MSB_FIRST ? img[c][WIDTH-1] : img[c][0];
    return b;
  endfunction

  function automatic image_t advance(input image_t img);
    image_t nxt;
    for (int c = 0; c < CHAINS; c++) nxt[c] = MSB_FIRST ? (img[c] << 1) : (img[c] >> 1);
    return nxt;
  endfunction

  tpic_clk_div #(.DIV(DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .enable (state != IDLE),
    .clear  (state == IDLE),
    .tick   (tick)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    shadow_d  = shadow;
    bit_cnt_d = bit_cnt;
    sout_d    = sout_q;
    sclk_d    = sclk_q;
    rck_d     = rck_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    clr_n_d   = clr_n_q;
    armed_d   = armed;
    en_n_d    = ~(bus.oe & armed);
    pending_d = pending | (bus.start & (state != IDLE));

    case (state)
      CLR: begin
        if (tick) begin
          clr_n_d = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Auto restarts wait one cycle past done; explicit requests start at once.
        if (bus.start || pending || (bus.auto && !done_q)) begin
          state_d   = SHIFT;
          shadow_d  = bus.data;
          sout_d    = lead_bits(bus.data);
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt_d == BIT_END) begin
              state_d = LATCH;
              sout_d  = '0;
              rck_d   = 1'b1;
            end else begin
              shadow_d = advance(shadow);
              sout_d   = lead_bits(shadow_d);
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_d = IDLE;
          rck_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          armed_d = 1'b1;
        end
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLR;
      shadow  <= '0;
      bit_cnt <= '0;
      sout_q  <= '0;
      sclk_q  <= 1'b0;
      rck_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_n_q <= 1'b0;
      en_n_q  <= 1'b1;
      pending <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_d;
      shadow  <= shadow_d;
      bit_cnt <= bit_cnt_d;
      sout_q  <= sout_d;
      sclk_q  <= sclk_d;
      rck_q   <= rck_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_n_q <= clr_n_d;
      en_n_q  <= en_n_d;
      pending <= pending_d;
      armed   <= armed_d;
    end
  end

  assign bus.sout  = sout_q;
  assign bus.sclk  = sclk_q;
  assign bus.rck   = rck_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.clr_n = clr_n_q;
  assign bus.en_n  = en_n_q;

endmodule

// File: tb/tb_tpic_chain_ctrl.sv
// Directed bench for tpic_chain_ctrl: three configurations share one clock and reset;
// expected chain images are queued at request time and popped at each rck rise.
module tb_tpic_chain_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // s=0: 16b x2 DIV2 LSB-first, s=1: 16b x2 DIV2 MSB-first, s=2: 2b x1 DIV1 LSB-first
  tpic_chain_ctrl_if #(.WIDTH(16), .CHAINS(2)) bus_a ();
  tpic_chain_ctrl_if #(.WIDTH(16), .CHAINS(2)) bus_b ();
  tpic_chain_ctrl_if #(.WIDTH(2),  .CHAINS(1)) bus_c ();

  tpic_chain_ctrl #(.WIDTH(16), .CHAINS(2), .DIV(2), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  tpic_chain_ctrl #(.WIDTH(16), .CHAINS(2), .DIV(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));
  tpic_chain_ctrl #(.WIDTH(2), .CHAINS(1), .DIV(1), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c));

  logic [31:0] sb_a[$];
  logic [31:0] sb_b[$];
  logic [31:0] sb_c[$];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic busy_of(int s);
    case (s) 0: return bus_a.busy; 1: return bus_b.busy; default: return bus_c.busy; endcase
  endfunction
  function automatic logic done_of(int s);
    case (s) 0: return bus_a.done; 1: return bus_b.done; default: return bus_c.done; endcase
  endfunction
  function automatic logic rck_of(int s);
    case (s) 0: return bus_a.rck; 1: return bus_b.rck; default: return bus_c.rck; endcase
  endfunction
  function automatic logic sclk_of(int s);
    case (s) 0: return bus_a.sclk; 1: return bus_b.sclk; default: return bus_c.sclk; endcase
  endfunction
  function automatic logic [1:0] sout_of(int s);
    case (s) 0: return bus_a.sout; 1: return bus_b.sout; default: return {1'b0, bus_c.sout}; endcase
  endfunction
  function automatic int width_of(int s);
    return (s == 2) ? 2 : 16;
  endfunction
  function automatic int chains_of(int s);
    return (s == 2) ? 1 : 2;
  endfunction
  function automatic bit msb_of(int s);
    return (s == 1);
  endfunction

  function automatic void push_exp(int s, logic [31:0] w);
    case (s) 0: sb_a.push_back(w); 1: sb_b.push_back(w); default: sb_c.push_back(w); endcase
  endfunction
  function automatic int sb_size(int s);
    case (s) 0: return sb_a.size(); 1: return sb_b.size(); default: return sb_c.size(); endcase
  endfunction
  function automatic logic [31:0] pop_exp(int s);
    case (s) 0: return sb_a.pop_front(); 1: return sb_b.pop_front(); default: return sb_c.pop_front(); endcase
  endfunction

  // Monitor: capture sout at each sclk rise, compare the assembled image at each rck rise.
  logic        sclk_prev [3] = '{1'b0, 1'b0, 1'b0};
  logic        rck_prev  [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0]  sout_prev [3] = '{2'b00, 2'b00, 2'b00};
  logic [31:0] cap       [3] = '{32'h0, 32'h0, 32'h0};
  int          nbits     [3] = '{0, 0, 0};
  int          rcks      [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      logic [1:0]  so;
      logic [31:0] exp_word;
      int          pos;
      so = sout_of(s);
      if (reset) begin
        nbits[s] = 0;
        cap[s]   = '0;
      end else begin
        if (sclk_of(s) && !sclk_prev[s]) begin
          check($sformatf("sout_stable_%0d", s), so, sout_prev[s]);
          if (nbits[s] < width_of(s)) begin
            pos = msb_of(s) ? width_of(s) - 1 - nbits[s] : nbits[s];
            for (int c = 0; c < chains_of(s); c++) cap[s][c*16 + pos] = so[c];
          end
          nbits[s]++;
        end
        if (rck_of(s) && !rck_prev[s]) begin
          rcks[s]++;
          check($sformatf("bits_per_frame_%0d", s), nbits[s], width_of(s));
          check($sformatf("sb_nonempty_%0d", s), sb_size(s) != 0, 1'b1);
          if (sb_size(s) != 0) begin
            exp_word = pop_exp(s);
            check($sformatf("frame_image_%0d", s), cap[s], exp_word);
          end
          nbits[s] = 0;
          cap[s]   = '0;
        end
      end
      sclk_prev[s] = sclk_of(s);
      rck_prev[s]  = rck_of(s);
      sout_prev[s] = so;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int s);
    case (s) 0: bus_a.start = 1'b1; 1: bus_b.start = 1'b1; default: bus_c.start = 1'b1; endcase
    @(negedge clk);
    case (s) 0: bus_a.start = 1'b0; 1: bus_b.start = 1'b0; default: bus_c.start = 1'b0; endcase
  endtask

  // Returns at the first negedge with busy low (the done cycle).
  task automatic measure_frame(input int s, output int busy_n, output int rck_n);
    int guard;
    guard = 0; busy_n = 0; rck_n = 0;
    while (!busy_of(s) && guard < 400) begin @(negedge clk); guard++; end
    check("frame_begin", busy_of(s), 1'b1);
    while (busy_of(s) && busy_n < 400) begin
      busy_n++;
      if (rck_of(s)) rck_n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int s);
    int guard;
    guard = 0;
    while (!done_of(s) && guard < 400) begin @(negedge clk); guard++; end
    check("done_seen", done_of(s), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, rn, r0;
    logic [4:0] sclk_pat;

    bus_a.data = '0; bus_a.start = 0; bus_a.auto = 0; bus_a.oe = 0;
    bus_b.data = '0; bus_b.start = 0; bus_b.auto = 0; bus_b.oe = 0;
    bus_c.data = '0; bus_c.start = 0; bus_c.auto = 0; bus_c.oe = 0;

    // 1. reset values, clr_n release timing, quiet idle
    step(2);
    check("rst_sclk", bus_a.sclk, 1'b0);
    check("rst_sout", bus_a.sout, 2'b00);
    check("rst_rck", bus_a.rck, 1'b0);
    check("rst_en_n", bus_a.en_n, 1'b1);
    check("rst_clr_n", bus_a.clr_n, 1'b0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_done", bus_a.done, 1'b0);
    reset = 1'b0;
    step(1);
    check("clr_n_low_cycle1", bus_a.clr_n, 1'b0);
    check("clr_n_div1_high", bus_c.clr_n, 1'b1);
    step(1);
    check("clr_n_high_after_div", bus_a.clr_n, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("idle_en_n", bus_a.en_n, 1'b1);
      check("idle_sout", bus_a.sout, 2'b00);
      check("idle_busy", bus_a.busy, 1'b0);
      step(1);
    end

    // 2. single LSB-first frame, en_n released one cycle after done
    bus_a.oe = 1'b1;
    bus_a.data = {16'h1234, 16'hAAAA};
    push_exp(0, {16'h1234, 16'hAAAA});
    pulse_start(0);
    bus_a.data = {16'hFFFF, 16'hFFFF};
    measure_frame(0, bn, rn);
    check("t2_busy_len", bn, 66);
    check("t2_rck_len", rn, 2);
    check("t2_done", bus_a.done, 1'b1);
    check("t2_en_n_at_done", bus_a.en_n, 1'b1);
    step(1);
    check("t2_done_one_cycle", bus_a.done, 1'b0);
    check("t2_en_n_after_done", bus_a.en_n, 1'b0);
    step(3);

    // 3. data change and two starts mid-frame: one extra frame, no gap
    r0 = rcks[0];
    bus_a.data = {16'hC3A5, 16'h0F1E};
    push_exp(0, {16'hC3A5, 16'h0F1E});
    pulse_start(0);
    step(20);
    bus_a.data = {16'h5A5A, 16'h9001};
    push_exp(0, {16'h5A5A, 16'h9001});
    pulse_start(0);
    step(3);
    pulse_start(0);
    wait_done(0);
    step(1);
    check("t3_pending_no_gap", bus_a.busy, 1'b1);
    measure_frame(0, bn, rn);
    check("t3_busy_len", bn, 66);
    step(8);
    check("t3_no_third_frame", bus_a.busy, 1'b0);
    check("t3_rck_pulses", rcks[0] - r0, 2);

    // 4. auto refresh, MSB-first, one idle cycle between frames
    r0 = rcks[1];
    bus_b.data = {16'hF00D, 16'h8001};
    for (int i = 0; i < 3; i++) push_exp(1, {16'hF00D, 16'h8001});
    bus_b.auto = 1'b1;
    for (int f = 0; f < 3; f++) begin
      measure_frame(1, bn, rn);
      check("t4_busy_len", bn, 66);
      check("t4_done", bus_b.done, 1'b1);
      if (f < 2) begin
        step(1);
        check("t4_gap_idle", bus_b.busy, 1'b0);
        step(1);
        check("t4_gap_restart", bus_b.busy, 1'b1);
        if (f == 1) bus_b.auto = 1'b0;
      end
    end
    step(6);
    check("t4_auto_stopped", bus_b.busy, 1'b0);
    check("t4_rck_pulses", rcks[1] - r0, 3);

    // 5. reset at bit 7 aborts the frame and disarms the outputs
    bus_a.data = {16'h1357, 16'hBEEF};
    push_exp(0, {16'h1357, 16'hBEEF});
    pulse_start(0);
    step(28);
    check("t5_mid_frame", bus_a.busy, 1'b1);
    r0 = rcks[0];
    #2 reset = 1'b1;
    #1;
    check("t5_rst_sclk", bus_a.sclk, 1'b0);
    check("t5_rst_sout", bus_a.sout, 2'b00);
    check("t5_rst_rck", bus_a.rck, 1'b0);
    check("t5_rst_busy", bus_a.busy, 1'b0);
    check("t5_rst_done", bus_a.done, 1'b0);
    check("t5_rst_en_n", bus_a.en_n, 1'b1);
    check("t5_rst_clr_n", bus_a.clr_n, 1'b0);
    step(2);
    sb_a.delete();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("t5_en_n_disarmed", bus_a.en_n, 1'b1);
    end
    check("t5_no_rck", rcks[0] - r0, 0);
    bus_a.data = {16'h0246, 16'h8ACE};
    push_exp(0, {16'h0246, 16'h8ACE});
    pulse_start(0);
    measure_frame(0, bn, rn);
    check("t5_busy_len", bn, 66);
    check("t5_en_n_at_done", bus_a.en_n, 1'b1);
    step(1);
    check("t5_en_n_rearmed", bus_a.en_n, 1'b0);

    // 6. DIV=1, WIDTH=2 corner
    sclk_pat = 5'b01010;
    bus_c.data = 2'b10;
    push_exp(2, 32'h2);
    pulse_start(2);
    for (int i = 0; i < 5; i++) begin
      check("t6_busy", bus_c.busy, 1'b1);
      check("t6_sclk", bus_c.sclk, sclk_pat[i]);
      check("t6_rck", bus_c.rck, (i == 4));
      step(1);
    end
    check("t6_busy_end", bus_c.busy, 1'b0);
    check("t6_done", bus_c.done, 1'b1);
    step(1);
    check("t6_en_n_oe_low", bus_c.en_n, 1'b1);
    bus_c.oe = 1'b1;
    step(1);
    check("t6_en_n_oe_high", bus_c.en_n, 1'b0);
    bus_c.data = 2'b01;
    push_exp(2, 32'h1);
    pulse_start(2);
    measure_frame(2, bn, rn);
    check("t6_busy_len", bn, 5);
    check("t6_rck_len", rn, 1);
    step(3);

    check("final_sb_a_empty", sb_a.size(), 0);
    check("final_sb_b_empty", sb_b.size(), 0);
    check("final_sb_c_empty", sb_c.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
